// File: rtl/dram_lut_rd_valid_mon.sv
// DRAM LUT read-path monitor: tracks each LUT read burst with a small FSM and
// publishes a registered 32-bit health word for the PPC software register.
//   [31] BUSY  [30] OVLP  [29] TMO  [28] UNEXP  [27:16] DONE  [15:0] see below
// Optional feature macro: DRAM_LUT_MON_LAT_EN
//   defined   : [15:0] = LAST_LAT (request-to-first-valid latency, saturating)
//   undefined : [15:0] = live beat count of the current burst
module dram_lut_rd_valid_mon #(
    parameter int unsigned EXP_BURST = 64,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic        user_clk,
    input  logic        user_rst,
    input  logic        lut_rd_req,
    input  logic        dram_rd_valid,
    input  logic        sw_clr,
    output logic [31:0] user_data_out
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned DONE_W = 12;

    localparam logic [CNT_W-1:0] EXP_BEATS = CNT_W'(EXP_BURST);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FIRST = 2'd1,
        ST_BURST      = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    beat_q, beat_d;
    logic [CNT_W-1:0]    idle_q, idle_d;
    logic [DONE_W-1:0]   done_q, done_d;
    logic                unexp_q, unexp_d;
    logic                ovlp_q, ovlp_d;
    logic                tmo_q, tmo_d;
    logic [31:0]         data_q, data_d;

    logic                done_inc;
    logic                unexp_set;
    logic                ovlp_set;
    logic                tmo_set;
    logic [CNT_W-1:0]    status_lo;

`ifdef DRAM_LUT_MON_LAT_EN
    logic [CNT_W-1:0]    lat_q, lat_d;
    logic [CNT_W-1:0]    last_lat_q, last_lat_d;
    logic [CNT_W-1:0]    lat_inc;

    // Saturating increment of the request-to-first-valid latency counter
    always_comb begin
        lat_inc = (lat_q == '1) ? lat_q : lat_q + CNT_W'(1);
    end
`endif

    // Next-state, counters and set events for the burst tracker
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        idle_d    = idle_q;
        done_inc  = 1'b0;
        unexp_set = 1'b0;
        ovlp_set  = 1'b0;
        tmo_set   = 1'b0;
`ifdef DRAM_LUT_MON_LAT_EN
        lat_d      = lat_q;
        last_lat_d = last_lat_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (dram_rd_valid) begin
                    unexp_set = 1'b1;
                end
                if (lut_rd_req) begin
                    state_d = ST_WAIT_FIRST;
                    idle_d  = '0;
                    beat_d  = '0;
`ifdef DRAM_LUT_MON_LAT_EN
                    lat_d   = '0;
`endif
                end
            end
            ST_WAIT_FIRST: begin
                if (lut_rd_req) begin
                    ovlp_set = 1'b1;
                end
`ifdef DRAM_LUT_MON_LAT_EN
                lat_d = lat_inc;
`endif
                if (dram_rd_valid) begin
                    idle_d = '0;
`ifdef DRAM_LUT_MON_LAT_EN
                    last_lat_d = lat_inc;
`endif
                    if (EXP_BEATS == CNT_W'(1)) begin
                        state_d  = ST_IDLE;
                        beat_d   = '0;
                        done_inc = 1'b1;
                    end else begin
                        state_d = ST_BURST;
                        beat_d  = CNT_W'(1);
                    end
                end else if (idle_q == TMO_LAST) begin
                    state_d = ST_IDLE;
                    beat_d  = '0;
                    tmo_set = 1'b1;
                end else begin
                    idle_d = idle_q + CNT_W'(1);
                end
            end
            ST_BURST: begin
                if (lut_rd_req) begin
                    ovlp_set = 1'b1;
                end
                if (dram_rd_valid) begin
                    idle_d = '0;
                    if (beat_q + CNT_W'(1) == EXP_BEATS) begin
                        state_d  = ST_IDLE;
                        beat_d   = '0;
                        done_inc = 1'b1;
                    end else begin
                        beat_d = beat_q + CNT_W'(1);
                    end
                end else if (idle_q == TMO_LAST) begin
                    state_d = ST_IDLE;
                    beat_d  = '0;
                    tmo_set = 1'b1;
                end else begin
                    idle_d = idle_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                beat_d  = '0;
                idle_d  = '0;
            end
        endcase
    end

    // Software clear of counters and sticky flags; a same-cycle set wins
    always_comb begin
        if (sw_clr) begin
            done_d = done_inc ? DONE_W'(1) : '0;
        end else begin
            done_d = done_q + DONE_W'(done_inc);
        end
        unexp_d = unexp_set | (unexp_q & ~sw_clr);
        ovlp_d  = ovlp_set  | (ovlp_q  & ~sw_clr);
        tmo_d   = tmo_set   | (tmo_q   & ~sw_clr);
    end

    // Status word assembled from registered state, registered once more
    always_comb begin
`ifdef DRAM_LUT_MON_LAT_EN
        status_lo = last_lat_q;
`else
        status_lo = beat_q;
`endif
        data_d = {(state_q != ST_IDLE), ovlp_q, tmo_q, unexp_q, done_q, status_lo};
    end

    // State and status registers with synchronous reset
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state_q    <= ST_IDLE;
            beat_q     <= '0;
            idle_q     <= '0;
            done_q     <= '0;
            unexp_q    <= 1'b0;
            ovlp_q     <= 1'b0;
            tmo_q      <= 1'b0;
            data_q     <= '0;
`ifdef DRAM_LUT_MON_LAT_EN
            lat_q      <= '0;
            last_lat_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            idle_q     <= idle_d;
            done_q     <= done_d;
            unexp_q    <= unexp_d;
            ovlp_q     <= ovlp_d;
            tmo_q      <= tmo_d;
            data_q     <= data_d;
`ifdef DRAM_LUT_MON_LAT_EN
            lat_q      <= lat_d;
            last_lat_q <= last_lat_d;
`endif
        end
    end

    assign user_data_out = data_q;

endmodule

// File: tb/tb_dram_lut_rd_valid_mon.sv
// Directed bench for dram_lut_rd_valid_mon with EXP_BURST=4, TIMEOUT=8.
// Expected words carry both the LAT_EN and beat-count forms of bits [15:0].
module tb_dram_lut_rd_valid_mon;

    logic        user_clk;
    logic        user_rst;
    logic        lut_rd_req;
    logic        dram_rd_valid;
    logic        sw_clr;
    logic [31:0] user_data_out;

    int total;
    int bad;

    typedef struct {
        logic        req;
        logic        valid;
        logic        clr;
        logic [31:0] exp_lat;
        logic [31:0] exp_beat;
    } vec_t;

    localparam int NVEC = 31;
    vec_t vecs [NVEC];

    dram_lut_rd_valid_mon #(
        .EXP_BURST(4),
        .TIMEOUT  (8)
    ) dut (
        .user_clk     (user_clk),
        .user_rst     (user_rst),
        .lut_rd_req   (lut_rd_req),
        .dram_rd_valid(dram_rd_valid),
        .sw_clr       (sw_clr),
        .user_data_out(user_data_out)
    );

    initial user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    // Drive one cycle of inputs, then sample 1 time unit after the edge
    task automatic step(input logic r, input logic v, input logic c);
        lut_rd_req    = r;
        dram_rd_valid = v;
        sw_clr        = c;
        @(posedge user_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] e_lat, input logic [31:0] e_beat);
        logic [31:0] e;
`ifdef DRAM_LUT_MON_LAT_EN
        e = e_lat;
`else
        e = e_beat;
`endif
        total++;
        if (user_data_out !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, user_data_out, e);
        end
    endtask

    // Request then four back-to-back valids (latency 1), plus one idle cycle
    task automatic burst();
        step(1'b1, 1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    function automatic vec_t mk(input logic r, input logic v, input logic c,
                                input logic [31:0] el, input logic [31:0] eb);
        vec_t t;
        t.req      = r;
        t.valid    = v;
        t.clr      = c;
        t.exp_lat  = el;
        t.exp_beat = eb;
        return t;
    endfunction

    initial begin
        total = 0;
        bad   = 0;

        // Nominal burst: request, valids 3 cycles later
        vecs[0]  = mk(1, 0, 0, 32'h0000_0000, 32'h0000_0000);
        vecs[1]  = mk(0, 0, 0, 32'h8000_0000, 32'h8000_0000);
        vecs[2]  = mk(0, 0, 0, 32'h8000_0000, 32'h8000_0000);
        vecs[3]  = mk(0, 1, 0, 32'h8000_0000, 32'h8000_0000);
        vecs[4]  = mk(0, 1, 0, 32'h8000_0003, 32'h8000_0001);
        vecs[5]  = mk(0, 1, 0, 32'h8000_0003, 32'h8000_0002);
        vecs[6]  = mk(0, 1, 0, 32'h8000_0003, 32'h8000_0003);
        vecs[7]  = mk(0, 0, 0, 32'h0001_0003, 32'h0001_0000);
        // Clear, then request with 2 valids and a timeout
        vecs[8]  = mk(0, 0, 1, 32'h0001_0003, 32'h0001_0000);
        vecs[9]  = mk(1, 0, 0, 32'h0000_0003, 32'h0000_0000);
        vecs[10] = mk(0, 0, 0, 32'h8000_0003, 32'h8000_0000);
        vecs[11] = mk(0, 1, 0, 32'h8000_0003, 32'h8000_0000);
        vecs[12] = mk(0, 1, 0, 32'h8000_0002, 32'h8000_0001);
        for (int i = 13; i <= 20; i++) begin
            vecs[i] = mk(0, 0, 0, 32'h8000_0002, 32'h8000_0002);
        end
        vecs[21] = mk(0, 0, 0, 32'h2000_0002, 32'h2000_0000);
        // Clear, unexpected valid, request, overlapping request in burst
        vecs[22] = mk(0, 0, 1, 32'h2000_0002, 32'h2000_0000);
        vecs[23] = mk(0, 1, 0, 32'h0000_0002, 32'h0000_0000);
        vecs[24] = mk(1, 0, 0, 32'h1000_0002, 32'h1000_0000);
        vecs[25] = mk(0, 1, 0, 32'h9000_0002, 32'h9000_0000);
        vecs[26] = mk(1, 0, 0, 32'h9000_0001, 32'h9000_0001);
        vecs[27] = mk(0, 1, 0, 32'hD000_0001, 32'hD000_0001);
        vecs[28] = mk(0, 1, 0, 32'hD000_0001, 32'hD000_0002);
        vecs[29] = mk(0, 1, 0, 32'hD000_0001, 32'hD000_0003);
        vecs[30] = mk(0, 0, 0, 32'h5001_0001, 32'h5001_0000);

        // Reset
        user_rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("reset", 32'h0, 32'h0);
        user_rst = 1'b0;

        // Table-driven sequence
        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].req, vecs[i].valid, vecs[i].clr);
            chk($sformatf("vec%0d", i), vecs[i].exp_lat, vecs[i].exp_beat);
        end

        // Clear vs. set collision with DONE previously 5
        step(1'b0, 1'b0, 1'b1);
        repeat (5) burst();
        chk("done5", 32'h0005_0001, 32'h0005_0000);
        step(1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("clr_vs_set", 32'h0001_0001, 32'h0001_0000);

        // DONE wrap after 4096 bursts from clear
        step(1'b0, 1'b0, 1'b1);
        for (int b = 0; b < 4095; b++) burst();
        chk("done_fff", 32'h0FFF_0001, 32'h0FFF_0000);
        burst();
        chk("done_wrap", 32'h0000_0001, 32'h0000_0000);

        // Mid-burst sample after 2 valids
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("mid_burst", 32'h8000_0001, 32'h8000_0002);

        // Reset mid-burst discards the burst without TMO
        user_rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        chk("rst_mid", 32'h0, 32'h0);
        user_rst = 1'b0;
        repeat (12) step(1'b0, 1'b0, 1'b0);
        chk("rst_no_tmo", 32'h0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
